// File: rtl/apb_req_arbiter.sv
// Two-requester APB front end: round-robin arbitration between core (0) and
// DMA (1), APB SETUP/ACCESS sequencing, PREADY timeout, and completion return.
module apb_req_arbiter #(
  parameter int TIMEOUT = 16
) (
  input  logic        PCLK,
  input  logic        PRESETn,
  input  logic        req0,
  input  logic        req1,
  input  logic        wr0,
  input  logic        wr1,
  input  logic [1:0]  sel0,
  input  logic [1:0]  sel1,
  input  logic [4:0]  addr0,
  input  logic [4:0]  addr1,
  input  logic [31:0] wdata0,
  input  logic [31:0] wdata1,
  output logic        gnt0,
  output logic        gnt1,
  output logic        done0,
  output logic        done1,
  output logic        err,
  output logic [31:0] rdata,
  output logic        PSEL1,
  output logic        PSEL2,
  output logic        PENABLE,
  output logic        PWRITE,
  output logic [4:0]  PADDR,
  output logic [31:0] PWDATA,
  input  logic        PREADY,
  input  logic [31:0] PRDATA
);

  typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS} state_t;

  localparam logic [8:0] TIMEOUT_W = 9'(TIMEOUT);

  state_t      r_state, w_nextState;
  logic [7:0]  r_waitCnt, w_nextWaitCnt;
  logic        r_lastGrant, w_nextLastGrant;
  logic        r_owner, w_nextOwner;
  logic        r_illegal, w_nextIllegal;

  logic        r_gnt0, r_gnt1, r_done0, r_done1, r_err;
  logic        r_psel1, r_psel2, r_penable, r_pwrite;
  logic [4:0]  r_paddr;
  logic [31:0] r_pwdata, r_rdata;

  logic        w_nextGnt0, w_nextGnt1, w_nextDone0, w_nextDone1, w_nextErr;
  logic        w_nextPsel1, w_nextPsel2, w_nextPenable, w_nextPwrite;
  logic [4:0]  w_nextPaddr;
  logic [31:0] w_nextPwdata, w_nextRdata;

  logic        w_timeout, w_complete, w_elig0, w_elig1, w_grantValid, w_grantId;
  logic        w_wrWin, w_selLegal;
  logic [1:0]  w_selWin;
  logic [4:0]  w_addrWin;
  logic [31:0] w_wdataWin;

  always_ff @(posedge PCLK or posedge PRESETn) begin
    if (PRESETn) begin
      r_state     <= ST_IDLE;
      r_waitCnt   <= 8'd0;
      r_lastGrant <= 1'b1;
      r_owner     <= 1'b0;
      r_illegal   <= 1'b0;
      r_gnt0      <= 1'b0;
      r_gnt1      <= 1'b0;
      r_done0     <= 1'b0;
      r_done1     <= 1'b0;
      r_err       <= 1'b0;
      r_psel1     <= 1'b0;
      r_psel2     <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= 5'd0;
      r_pwdata    <= 32'd0;
      r_rdata     <= 32'd0;
    end else begin
      r_state     <= w_nextState;
      r_waitCnt   <= w_nextWaitCnt;
      r_lastGrant <= w_nextLastGrant;
      r_owner     <= w_nextOwner;
      r_illegal   <= w_nextIllegal;
      r_gnt0      <= w_nextGnt0;
      r_gnt1      <= w_nextGnt1;
      r_done0     <= w_nextDone0;
      r_done1     <= w_nextDone1;
      r_err       <= w_nextErr;
      r_psel1     <= w_nextPsel1;
      r_psel2     <= w_nextPsel2;
      r_penable   <= w_nextPenable;
      r_pwrite    <= w_nextPwrite;
      r_paddr     <= w_nextPaddr;
      r_pwdata    <= w_nextPwdata;
      r_rdata     <= w_nextRdata;
    end
  end

  // The finishing owner's req is masked so a back-to-back grant goes to the other side.
  always_comb begin
    w_timeout    = ({1'b0, r_waitCnt} + 9'd1) == TIMEOUT_W;
    w_complete   = (r_state == ST_ACCESS) && (r_illegal || PREADY || w_timeout);
    w_elig0      = req0 && !(w_complete && (r_owner == 1'b0));
    w_elig1      = req1 && !(w_complete && (r_owner == 1'b1));
    w_grantValid = ((r_state == ST_IDLE) || w_complete) && (w_elig0 || w_elig1);
    w_grantId    = (w_elig0 && w_elig1) ? ~r_lastGrant : w_elig1;
    w_wrWin      = w_grantId ? wr1 : wr0;
    w_selWin     = w_grantId ? sel1 : sel0;
    w_addrWin    = w_grantId ? addr1 : addr0;
    w_wdataWin   = w_grantId ? wdata1 : wdata0;
    w_selLegal   = (w_selWin == 2'd1) || (w_selWin == 2'd2);

    w_nextState     = r_state;
    w_nextWaitCnt   = r_waitCnt;
    w_nextLastGrant = r_lastGrant;
    w_nextOwner     = r_owner;
    w_nextIllegal   = r_illegal;
    case (r_state)
      ST_IDLE: begin
        if (w_grantValid) begin
          w_nextState   = ST_SETUP;
          w_nextOwner   = w_grantId;
          w_nextIllegal = !w_selLegal;
        end
      end
      ST_SETUP: w_nextState = ST_ACCESS;
      ST_ACCESS: begin
        if (w_complete) begin
          w_nextWaitCnt   = 8'd0;
          w_nextLastGrant = r_owner;
          if (w_grantValid) begin
            w_nextState   = ST_SETUP;
            w_nextOwner   = w_grantId;
            w_nextIllegal = !w_selLegal;
          end else begin
            w_nextState = ST_IDLE;
          end
        end else begin
          w_nextWaitCnt = r_waitCnt + 8'd1;
        end
      end
      default: w_nextState = ST_IDLE;
    endcase
  end

  // Completion is applied first; a same-edge grant then overrides the bus fields.
  always_comb begin
    w_nextGnt0    = r_gnt0;
    w_nextGnt1    = r_gnt1;
    w_nextDone0   = 1'b0;
    w_nextDone1   = 1'b0;
    w_nextErr     = 1'b0;
    w_nextPsel1   = r_psel1;
    w_nextPsel2   = r_psel2;
    w_nextPenable = r_penable;
    w_nextPwrite  = r_pwrite;
    w_nextPaddr   = r_paddr;
    w_nextPwdata  = r_pwdata;
    w_nextRdata   = r_rdata;

    if (r_state == ST_SETUP)
      w_nextPenable = !r_illegal;

    if (w_complete) begin
      w_nextDone0   = (r_owner == 1'b0);
      w_nextDone1   = (r_owner == 1'b1);
      w_nextErr     = r_illegal || !PREADY;
      w_nextPenable = 1'b0;
      w_nextGnt0    = 1'b0;
      w_nextGnt1    = 1'b0;
      w_nextPsel1   = 1'b0;
      w_nextPsel2   = 1'b0;
      if (!r_illegal && PREADY && !r_pwrite)
        w_nextRdata = PRDATA;
    end

    if (w_grantValid) begin
      w_nextGnt0    = (w_grantId == 1'b0);
      w_nextGnt1    = (w_grantId == 1'b1);
      w_nextPsel1   = (w_selWin == 2'd1);
      w_nextPsel2   = (w_selWin == 2'd2);
      w_nextPenable = 1'b0;
      w_nextPwrite  = w_wrWin;
      w_nextPaddr   = w_addrWin;
      if (w_wrWin)
        w_nextPwdata = w_wdataWin;
    end
  end

  assign gnt0    = r_gnt0;
  assign gnt1    = r_gnt1;
  assign done0   = r_done0;
  assign done1   = r_done1;
  assign err     = r_err;
  assign rdata   = r_rdata;
  assign PSEL1   = r_psel1;
  assign PSEL2   = r_psel2;
  assign PENABLE = r_penable;
  assign PWRITE  = r_pwrite;
  assign PADDR   = r_paddr;
  assign PWDATA  = r_pwdata;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Self-checking bench for apb_req_arbiter: vector table of single transfers,
// plus hand sequences for contention/back-to-back and reset mid-ACCESS.
module tb_apb_req_arbiter;

  localparam int TMO = 4;

  logic        PCLK = 1'b0;
  logic        PRESETn;
  logic        req0, req1, wr0, wr1;
  logic [1:0]  sel0, sel1;
  logic [4:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        gnt0, gnt1, done0, done1, err;
  logic [31:0] rdata;
  logic        PSEL1, PSEL2, PENABLE, PWRITE;
  logic [4:0]  PADDR;
  logic [31:0] PWDATA;
  logic        PREADY;
  logic [31:0] PRDATA;

  always #5 PCLK = ~PCLK;

  apb_req_arbiter #(.TIMEOUT(TMO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .sel0(sel0), .sel1(sel1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .err(err), .rdata(rdata),
    .PSEL1(PSEL1), .PSEL2(PSEL2), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PREADY(PREADY), .PRDATA(PRDATA)
  );

  typedef struct {
    logic        who;
    logic        wr;
    logic [1:0]  sel;
    logic [4:0]  addr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] prdata;
    logic        expErr;
    logic [31:0] expRdata;
    int          expLat;
  } vec_t;

  typedef struct {
    logic        who;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t sbQ[$];
  vec_t vecs[8];
  int   checks = 0;
  int   errors = 0;

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge PCLK);
    #1;
  endtask

  // Pop the oldest expected completion and compare it with what the DUT returned.
  task automatic checkOutput(input logic whoAct, input logic errAct, input logic [31:0] rdAct);
    exp_t e;
    if (sbQ.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL sb_empty: done seen from %0d with no expected entry", whoAct);
    end else begin
      e = sbQ.pop_front();
      checkVal("sb_who", 32'(whoAct), 32'(e.who));
      checkVal("sb_err", 32'(errAct), 32'(e.err));
      checkVal("sb_rdata", rdAct, e.rdata);
    end
  endtask

  task automatic driveReq(input logic who, input logic on, input logic wr, input logic [1:0] sel,
                          input logic [4:0] addr, input logic [31:0] wdata);
    if (who) begin
      req1 = on; wr1 = wr; sel1 = sel; addr1 = addr; wdata1 = wdata;
    end else begin
      req0 = on; wr0 = wr; sel0 = sel; addr0 = addr; wdata0 = wdata;
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    logic legal;
    int   lat;
    logic got;
    legal = (v.sel == 2'd1) || (v.sel == 2'd2);
    PREADY = 1'b0;
    PRDATA = v.prdata;
    driveReq(v.who, 1'b1, v.wr, v.sel, v.addr, v.wdata);
    sbQ.push_back('{v.who, v.expErr, v.expRdata});
    tick();
    checkVal("grant_gnt", 32'(v.who ? gnt1 : gnt0), 32'd1);
    checkVal("grant_psel1", 32'(PSEL1), 32'(legal && v.sel == 2'd1));
    checkVal("grant_psel2", 32'(PSEL2), 32'(legal && v.sel == 2'd2));
    checkVal("grant_penable", 32'(PENABLE), 32'd0);
    checkVal("grant_paddr", 32'(PADDR), 32'(v.addr));
    checkVal("grant_pwrite", 32'(PWRITE), 32'(v.wr));
    if (v.wr) checkVal("grant_pwdata", PWDATA, v.wdata);
    tick();
    checkVal("access_penable", 32'(PENABLE), 32'(legal));
    lat = 0;
    got = 1'b0;
    while (!got && lat < 20) begin
      PREADY = (lat >= v.waits);
      tick();
      lat++;
      if (done0 || done1) got = 1'b1;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("[TB] FAIL done_wait: no done within %0d cycles", lat);
    end else begin
      checkVal("done_latency", 32'(lat), 32'(v.expLat));
      checkVal("done_exclusive", 32'(done0 & done1), 32'd0);
      checkOutput(done1, err, rdata);
      checkVal("done_psel", 32'({PSEL1, PSEL2, PENABLE, gnt0, gnt1}), 32'd0);
    end
    driveReq(v.who, 1'b0, v.wr, v.sel, v.addr, v.wdata);
    PREADY = 1'b0;
    tick();
    checkVal("idle_quiet", 32'({done0, done1, gnt0, gnt1, PSEL1, PSEL2}), 32'd0);
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int n;
    int cyc;

    vecs[0] = '{1'b0, 1'b1, 2'd1, 5'h0A, 32'hDEADBEEF, 0,  32'h0,        1'b0, 32'h0,        1};
    vecs[1] = '{1'b1, 1'b0, 2'd2, 5'h03, 32'h0,        3,  32'h12345678, 1'b0, 32'h12345678, 4};
    vecs[2] = '{1'b0, 1'b0, 2'd1, 5'h1F, 32'h0,        99, 32'hAAAA5555, 1'b1, 32'h12345678, TMO};
    vecs[3] = '{1'b1, 1'b1, 2'd0, 5'h04, 32'h01020304, 0,  32'h55555555, 1'b1, 32'h12345678, 1};
    vecs[4] = '{1'b0, 1'b0, 2'd3, 5'h05, 32'h0,        0,  32'h66666666, 1'b1, 32'h12345678, 1};
    vecs[5] = '{1'b1, 1'b1, 2'd1, 5'h11, 32'hA5A5A5A5, 2,  32'h0,        1'b0, 32'h12345678, 3};
    vecs[6] = '{1'b0, 1'b0, 2'd2, 5'h00, 32'h0,        3,  32'hCAFEF00D, 1'b0, 32'hCAFEF00D, 4};
    vecs[7] = '{1'b1, 1'b0, 2'd2, 5'h1C, 32'h0,        4,  32'h77777777, 1'b1, 32'hCAFEF00D, TMO};

    PRESETn = 1'b1;
    req0 = 0; req1 = 0; wr0 = 0; wr1 = 0; sel0 = 0; sel1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0; PREADY = 0; PRDATA = 0;
    repeat (2) tick();
    checkVal("reset_ctrl", 32'({gnt0, gnt1, done0, done1, err, PSEL1, PSEL2, PENABLE, PWRITE}), 32'd0);
    checkVal("reset_paddr", 32'(PADDR), 32'd0);
    checkVal("reset_pwdata", PWDATA, 32'd0);
    checkVal("reset_rdata", rdata, 32'd0);
    PRESETn = 1'b0;
    tick();

    // Contention: both rise together, requester 0 first, then strict alternation.
    driveReq(1'b0, 1'b1, 1'b1, 2'd1, 5'h01, 32'h11111111);
    driveReq(1'b1, 1'b1, 1'b1, 2'd2, 5'h02, 32'h22222222);
    PREADY = 1'b1;
    sbQ.push_back('{1'b0, 1'b0, 32'h0});
    sbQ.push_back('{1'b1, 1'b0, 32'h0});
    sbQ.push_back('{1'b0, 1'b0, 32'h0});
    sbQ.push_back('{1'b1, 1'b0, 32'h0});
    n = 0;
    cyc = 0;
    while (n < 4 && cyc < 30) begin
      tick();
      cyc++;
      if (done0 || done1) begin
        checkVal("b2b_done_excl", 32'(done0 & done1), 32'd0);
        checkOutput(done1, err, rdata);
        checkVal("b2b_new_gnt", 32'(done0 ? gnt1 : gnt0), 32'd1);
        checkVal("b2b_old_gnt", 32'(done0 ? gnt0 : gnt1), 32'd0);
        checkVal("b2b_new_psel", 32'(done0 ? PSEL2 : PSEL1), 32'd1);
        checkVal("b2b_penable", 32'(PENABLE), 32'd0);
        n++;
      end
    end
    if (n < 4) begin
      checks++;
      errors++;
      $display("[TB] FAIL contention_wait: %0d of 4 completions seen", n);
    end
    req0 = 1'b0;
    req1 = 1'b0;
    PREADY = 1'b0;
    repeat (2) tick();
    PREADY = 1'b1;
    repeat (3) tick();
    PREADY = 1'b0;
    checkVal("contention_drained", 32'({gnt0, gnt1, PSEL1, PSEL2, PENABLE}), 32'd0);
    sbQ.delete();

    for (int i = 0; i < 8; i++) applyStimulus(vecs[i]);

    // Reset mid-ACCESS: everything drops immediately, then a pending req0 restarts from IDLE.
    driveReq(1'b0, 1'b1, 1'b0, 2'd1, 5'h07, 32'h0);
    PREADY = 1'b0;
    tick();
    tick();
    checkVal("prereset_penable", 32'(PENABLE), 32'd1);
    PRESETn = 1'b1;
    #1;
    checkVal("midrst_ctrl", 32'({gnt0, gnt1, done0, done1, err, PSEL1, PSEL2, PENABLE, PWRITE}), 32'd0);
    checkVal("midrst_paddr", 32'(PADDR), 32'd0);
    checkVal("midrst_rdata", rdata, 32'd0);
    tick();
    checkVal("midrst_no_done", 32'({done0, done1}), 32'd0);
    PRESETn = 1'b0;
    PREADY = 1'b1;
    PRDATA = 32'h0BADF00D;
    sbQ.push_back('{1'b0, 1'b0, 32'h0BADF00D});
    tick();
    checkVal("rearb_gnt0", 32'(gnt0), 32'd1);
    checkVal("rearb_psel1", 32'(PSEL1), 32'd1);
    checkVal("rearb_penable", 32'(PENABLE), 32'd0);
    tick();
    checkVal("rearb_access", 32'(PENABLE), 32'd1);
    tick();
    checkVal("rearb_done0", 32'(done0), 32'd1);
    checkOutput(done1, err, rdata);
    req0 = 1'b0;
    PREADY = 1'b0;
    tick();
    checkVal("sb_drained", 32'(sbQ.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb_req_arbiter.md
# apb_req_arbiter

Two-requester APB front end that shares the single APB bus between requester 0 (core) and requester 1 (DMA). It arbitrates round-robin and sequences the winning request through the IDLE/SETUP/ACCESS protocol, driving PSEL1/PSEL2, PENABLE, PWRITE, PADDR and PWDATA. It waits on PREADY with a timeout and returns read data and completion status to the owning requester.

## Interface
- TIMEOUT, default 16: ACCESS cycles with PREADY low before forced error completion; legal range 2..255.
- PCLK  in  1  clock, all state updates on rising edge.
- PRESETn  in  1  asynchronous, active-high reset.
- req0 / req1  in  1  request level; held, with its fields stable, until the matching done pulse.
- wr0 / wr1  in  1  1 = write, 0 = read.
- sel0 / sel1  in  2  slave select: 1 selects PSEL1, 2 selects PSEL2; 0 and 3 are illegal.
- addr0 / addr1  in  5  transfer address.
- wdata0 / wdata1  in  32  write data.
- gnt0 / gnt1  out  1  high while that requester owns the bus (SETUP and ACCESS).
- done0 / done1  out  1  one-cycle completion pulse.
- err  out  1  valid with done: 1 = timeout or illegal select.
- rdata  out  32  read data, updated only on a successful read completion; held otherwise.
- PSEL1 / PSEL2 / PENABLE / PWRITE  out  1  APB control.
- PADDR  out  5; PWDATA  out  32  APB address and write data.
- PREADY  in  1; PRDATA  in  32  APB slave response.

## Operation
- All outputs are registered. Reset drives every output to 0, the state to IDLE, the wait counter to 0 and last_grant to 1, so requester 0 wins the first tie.
- IDLE: if any req is high at the edge, the arbiter picks the winner:
  - only one requester asserting: it wins;
  - both asserting: the requester not equal to last_grant wins.
- On the grant edge the arbiter latches the winner's wr/sel/addr/wdata into PWRITE/PADDR/PWDATA, sets gnt, and sets PSEL1 if sel=1 or PSEL2 if sel=2, with PENABLE=0. It then moves to SETUP.
- SETUP: lasts exactly one cycle. The next edge sets PENABLE=1 (only when sel is legal) and moves to ACCESS.
- ACCESS, on each edge:
  - PREADY=1: complete with err=0. On a read, load rdata from PRDATA.
  - PREADY=0: increment the wait counter. When the counter reaches TIMEOUT, complete with err=1 and leave rdata unchanged.
  - sel illegal: PSEL1, PSEL2 and PENABLE stay 0 for the whole transfer. PREADY is ignored, and the transfer completes with err=1 on the first ACCESS edge.
- Completion edge:
  - pulse the winner's done for one cycle, drive err, clear PENABLE and the wait counter, and set last_grant to the winner;
  - the winner's own req is masked in this cycle, because the requester has not yet seen done;
  - if the other requester's req is high, grant it on the same edge: load its fields, set its PSEL and gnt, and go straight to SETUP (back-to-back, no IDLE cycle);
  - otherwise clear PSELx and gnt and go to IDLE.
- A requester dropping req mid-transfer does not abort the transfer. Completion still pulses done.
- PWDATA holds its last value on reads; PWRITE/PADDR/PWDATA hold their values in IDLE.
- Wait-counter width is 8 bits. The counter never wraps, because completion occurs at TIMEOUT.

## Timing
- Grant latency: req sampled high in IDLE at edge N gives PSELx/gnt high after edge N, PENABLE high after N+1, and done after N+2 at the earliest (zero wait states).
- Wait states: each PREADY-low ACCESS cycle adds one cycle. Timeout done occurs TIMEOUT cycles after entering ACCESS.
- Back-to-back handoff: done for requester A and the new SETUP for requester B share the same cycle. PENABLE is low in that cycle.
- done0 and done1 are never high together; gnt0 and gnt1 are never high together.
- Reset mid-transfer forces all outputs to 0 immediately (asynchronously). No done is issued for the aborted transfer, and rdata returns to 0.

## Test plan
- Single write: req0 with wr0=1, sel0=1, addr0=5'h0A, wdata0=32'hDEADBEEF, PREADY=1 → PSEL1 high 2 cycles with PENABLE high in the 2nd, PADDR=0A, PWDATA=DEADBEEF; done0 one cycle after ACCESS, err=0.
- Read with waits: req1 with wr1=0, sel1=2, addr1=5'h03; PREADY low 3 ACCESS cycles then high with PRDATA=32'h12345678 → PSEL2 high 5 cycles, done1 pulse, rdata=12345678, err=0.
- Contention: req0 and req1 rise in the same cycle after reset → requester 0 is served first. Requester 1 is granted on requester 0's done edge, with no IDLE cycle in between. With both re-requesting, the grant order alternates 0,1,0,1.
- Timeout: TIMEOUT=4, req0 read, PREADY held 0 → done0 with err=1 exactly 4 cycles after PENABLE rises; rdata unchanged; PSEL1 and PENABLE low afterwards.
- Illegal select: req1 with sel1=0 → PSEL1, PSEL2 and PENABLE stay 0; done1 with err=1 two cycles after grant.
- Reset mid-ACCESS: assert PRESETn while PENABLE=1 → all outputs 0 in the same cycle, no done; after release, a pending req0 is re-arbitrated from IDLE.
